// File: rtl/iic_eeprom_target_if.sv
`default_nettype none
// ============================================================================
// Module      : iic_eeprom_target_if
// Description : Two-wire bus bundle between an IIC master and the EEPROM
//               target. scl_i/sda_i carry the wire levels; sda_oe is the
//               target's open-drain pull-down request.
// Revision    : 1.0 - initial release
// ============================================================================
interface iic_eeprom_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface
`default_nettype wire

// File: rtl/iic_eeprom_target.sv
`default_nettype none
// ============================================================================
// Module      : iic_eeprom_target
// Description : IIC target emulating an AT24C64-style serial EEPROM. 7-bit
//               device address, 2-byte word address, random/sequential read
//               and page write. SCL/SDA are oversampled on sys_clk and SDA is
//               driven open-drain through sda_oe.
//               Optional macro IIC_WP_EN adds a write-protect input wp.
// Revision    : 1.0 - initial release
// ============================================================================
module iic_eeprom_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         ADDR_W      = 13,
    parameter int         PAGE_W      = 5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
`ifdef IIC_WP_EN
    input  logic              wp,
`endif
    iic_eeprom_target_if.slave bus,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DEVADR  = 4'd1,
        S_ACK_DEV = 4'd2,
        S_ADR_HI  = 4'd3,
        S_ACK_HI  = 4'd4,
        S_ADR_LO  = 4'd5,
        S_ACK_LO  = 4'd6,
        S_WR_DATA = 4'd7,
        S_ACK_WR  = 4'd8,
        S_RD_DATA = 4'd9,
        S_RD_ACK  = 4'd10,
        S_WAIT_P  = 4'd11
    } state_t;

    localparam logic [3:0] c_BYTE_DONE = 4'd8;

    // Synchronizers and edge history
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    // Protocol state
    state_t              r_state,   w_state_nxt;
    logic                r_sda_oe,  w_sda_oe_nxt;
    logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]          r_shift,   w_shift_nxt;
    logic [ADDR_W-1:0]   r_ptr,     w_ptr_nxt;
    logic [ADDR_W-9:0]   r_adr_hi,  w_adr_hi_nxt;
    logic                r_rw,      w_rw_nxt;
    logic                r_mack,    w_mack_nxt;
    logic                w_mem_we;
    logic                w_wp;
    logic [7:0]          w_byte;
    logic [7:0]          w_mem_rd;
    logic [PAGE_W-1:0]   w_page_off;
    logic [ADDR_W-1:0]   w_ptr_page_inc;

    logic [7:0] r_mem [0:(2**ADDR_W)-1];

`ifdef IIC_WP_EN
    assign w_wp = wp;
`else
    assign w_wp = 1'b0;
`endif

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = ~r_scl_prev &  w_scl_s;
    assign w_scl_fall =  r_scl_prev & ~w_scl_s;
    // START/STOP need SCL high on both samples so a data change cannot alias
    assign w_start    = r_scl_prev & w_scl_s &  r_sda_prev & ~w_sda_s;
    assign w_stop     = r_scl_prev & w_scl_s & ~r_sda_prev &  w_sda_s;

    // Byte as it will stand once the bit on the current SCL rise is shifted in
    assign w_byte         = {r_shift[6:0], w_sda_s};
    assign w_mem_rd       = r_mem[r_ptr];
    assign w_page_off     = r_ptr[PAGE_W-1:0] + PAGE_W'(1);
    assign w_ptr_page_inc = {r_ptr[ADDR_W-1:PAGE_W], w_page_off};

    // Bring SCL/SDA into the clock domain; idle bus level is high
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    // Next-state and datapath decode; bus conditions override every state
    always_comb begin
        w_state_nxt   = r_state;
        w_sda_oe_nxt  = r_sda_oe;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_adr_hi_nxt  = r_adr_hi;
        w_rw_nxt      = r_rw;
        w_mack_nxt    = r_mack;
        w_mem_we      = 1'b0;

        if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
        end else if (w_start) begin
            w_state_nxt   = S_DEVADR;
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                S_DEVADR, S_ADR_HI, S_ADR_LO, S_WR_DATA: begin
                    if (w_scl_rise && (r_bit_cnt != c_BYTE_DONE)) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        // Byte-complete actions happen on the 8th rise
                        if (r_bit_cnt == 4'd7) begin
                            if (r_state == S_ADR_HI) begin
                                w_adr_hi_nxt = w_byte[ADDR_W-9:0];
                            end else if (r_state == S_ADR_LO) begin
                                w_ptr_nxt = {r_adr_hi, w_byte};
                            end else if (r_state == S_WR_DATA) begin
                                w_mem_we  = ~w_wp;
                                w_ptr_nxt = w_ptr_page_inc;
                            end
                        end
                    end else if (w_scl_fall && (r_bit_cnt == c_BYTE_DONE)) begin
                        // Enter the acknowledge slot on the 8th fall
                        w_bit_cnt_nxt = 4'd0;
                        if (r_state == S_DEVADR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_state_nxt  = S_ACK_DEV;
                                w_sda_oe_nxt = 1'b1;
                                w_rw_nxt     = r_shift[0];
                            end else begin
                                w_state_nxt  = S_WAIT_P;
                            end
                        end else if (r_state == S_ADR_HI) begin
                            w_state_nxt  = S_ACK_HI;
                            w_sda_oe_nxt = 1'b1;
                        end else if (r_state == S_ADR_LO) begin
                            w_state_nxt  = S_ACK_LO;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = S_ACK_WR;
                            w_sda_oe_nxt = ~w_wp;
                        end
                    end
                end
                S_ACK_DEV: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_state_nxt  = S_RD_DATA;
                            w_shift_nxt  = w_mem_rd;
                            w_sda_oe_nxt = ~w_mem_rd[7];
                        end else begin
                            w_state_nxt  = S_ADR_HI;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_ACK_HI: begin
                    if (w_scl_fall) begin
                        w_state_nxt  = S_ADR_LO;
                        w_sda_oe_nxt = 1'b0;
                    end
                end
                S_ACK_LO, S_ACK_WR: begin
                    if (w_scl_fall) begin
                        w_state_nxt  = S_WR_DATA;
                        w_sda_oe_nxt = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise && (r_bit_cnt != c_BYTE_DONE)) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == c_BYTE_DONE) begin
                            // Release SDA so the master can acknowledge
                            w_state_nxt   = S_RD_ACK;
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = ~w_sda_s;
                        if (!w_sda_s) begin
                            w_ptr_nxt = r_ptr + ADDR_W'(1);
                        end
                    end else if (w_scl_fall) begin
                        if (r_mack) begin
                            w_state_nxt   = S_RD_DATA;
                            w_shift_nxt   = w_mem_rd;
                            w_sda_oe_nxt  = ~w_mem_rd[7];
                            w_bit_cnt_nxt = 4'd0;
                        end else begin
                            w_state_nxt   = S_WAIT_P;
                        end
                    end
                end
                S_IDLE, S_WAIT_P: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= '0;
            r_adr_hi  <= '0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_adr_hi  <= w_adr_hi_nxt;
            r_rw      <= w_rw_nxt;
            r_mack    <= w_mack_nxt;
            wr_pulse  <= w_mem_we;
            if (w_mem_we) begin
                wr_addr <= r_ptr;
            end
        end
    end

    // Byte storage; contents survive reset
    always_ff @(posedge sys_clk) begin
        if (w_mem_we && !sys_rst) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    assign bus.sda_oe = r_sda_oe;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iic_eeprom_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_iic_eeprom_target
// Description : Directed bench for iic_eeprom_target. Acts as the IIC master
//               with an open-drain wire model, checks ACK bits, read data,
//               write strobes and reset behaviour. Build with IIC_WP_EN to
//               also exercise write protection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iic_eeprom_target;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        m_sda;
    logic        busy;
    logic        wr_pulse;
    logic [12:0] wr_addr;
`ifdef IIC_WP_EN
    logic        wp;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pulse = 0;
    logic [12:0] addr_log [0:31];

    iic_eeprom_target_if bus ();

    // Open-drain wire: either side can pull low
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    iic_eeprom_target dut (
        .sys_clk  (clk),
        .sys_rst  (sys_rst),
`ifdef IIC_WP_EN
        .wp       (wp),
`endif
        .bus      (bus),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    // Log every write strobe and its address
    always @(negedge clk) begin
        if (wr_pulse) begin
            if (n_pulse < 32) addr_log[n_pulse] <= wr_addr;
            n_pulse <= n_pulse + 1;
        end
    end

    // Hard time limit
    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic tx, output logic rx);
        m_sda = tx;
        wait_cyc(4);
        bus.scl_i = 1'b1;
        wait_cyc(4);
        rx = bus.sda_i;
        wait_cyc(4);
        bus.scl_i = 1'b0;
        wait_cyc(4);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1;
        wait_cyc(4);
        bus.scl_i = 1'b1;
        wait_cyc(8);
        m_sda = 1'b0;
        wait_cyc(8);
        bus.scl_i = 1'b0;
        wait_cyc(4);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0;
        wait_cyc(4);
        bus.scl_i = 1'b1;
        wait_cyc(8);
        m_sda = 1'b1;
        wait_cyc(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] data);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, r);
            data[i] = r;
        end
        bit_cycle(nack, r);
    endtask

    // Address phase with acks checked, then repeated START with read
    task automatic set_ptr_read(input logic [7:0] hi, input logic [7:0] lo, input string tag);
        logic a;
        i2c_start;
        write_byte(8'hA0, a); check({tag, "_ack_dev"}, {15'd0, a}, 16'd0);
        write_byte(hi, a);    check({tag, "_ack_hi"},  {15'd0, a}, 16'd0);
        write_byte(lo, a);    check({tag, "_ack_lo"},  {15'd0, a}, 16'd0);
        i2c_start;
        write_byte(8'hA1, a); check({tag, "_ack_rd"},  {15'd0, a}, 16'd0);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         p0;

        sys_rst   = 1'b1;
        m_sda     = 1'b1;
        bus.scl_i = 1'b1;
`ifdef IIC_WP_EN
        wp        = 1'b0;
`endif
        wait_cyc(5);
        check("rst_sda_oe",   {15'd0, bus.sda_oe}, 16'd0);
        check("rst_busy",     {15'd0, busy},       16'd0);
        check("rst_wr_pulse", {15'd0, wr_pulse},   16'd0);
        check("rst_wr_addr",  {3'd0, wr_addr},     16'd0);
        sys_rst = 1'b0;
        wait_cyc(5);

        // Single byte write 0x5A to 0x0123
        i2c_start;
        check("busy_after_start", {15'd0, busy}, 16'd1);
        write_byte(8'hA0, a); check("w1_ack_dev",  {15'd0, a}, 16'd0);
        write_byte(8'h01, a); check("w1_ack_hi",   {15'd0, a}, 16'd0);
        write_byte(8'h23, a); check("w1_ack_lo",   {15'd0, a}, 16'd0);
        write_byte(8'h5A, a); check("w1_ack_data", {15'd0, a}, 16'd0);
        i2c_stop;
        check("w1_pulses",    n_pulse[15:0],          16'd1);
        check("w1_addr",      {3'd0, addr_log[0]},    16'h0123);
        check("w1_busy_stop", {15'd0, busy},          16'd0);

        // Random read from 0x0123
        set_ptr_read(8'h01, 8'h23, "rr");
        read_byte(1'b1, d);
        check("rr_data", {8'd0, d}, 16'h005A);
        i2c_stop;
        check("rr_sda_oe_stop", {15'd0, bus.sda_oe}, 16'd0);
        check("rr_busy_stop",   {15'd0, busy},       16'd0);

        // Page write from 0x001E wraps to 0x0000
        p0 = n_pulse;
        i2c_start;
        write_byte(8'hA0, a); check("pw_ack_dev", {15'd0, a}, 16'd0);
        write_byte(8'h00, a);
        write_byte(8'h1E, a);
        write_byte(8'h11, a); check("pw_ack_d0", {15'd0, a}, 16'd0);
        write_byte(8'h22, a); check("pw_ack_d1", {15'd0, a}, 16'd0);
        write_byte(8'h33, a); check("pw_ack_d2", {15'd0, a}, 16'd0);
        i2c_stop;
        check("pw_pulses", 16'(n_pulse - p0),      16'd3);
        check("pw_addr0",  {3'd0, addr_log[p0]},   16'h001E);
        check("pw_addr1",  {3'd0, addr_log[p0+1]}, 16'h001F);
        check("pw_addr2",  {3'd0, addr_log[p0+2]}, 16'h0000);

        // Read back 0x001E..0x001F sequentially
        set_ptr_read(8'h00, 8'h1E, "sq1");
        read_byte(1'b0, d); check("sq1_d0", {8'd0, d}, 16'h0011);
        read_byte(1'b1, d); check("sq1_d1", {8'd0, d}, 16'h0022);
        i2c_stop;

        // Top address, then sequential read wrapping 0x1FFF -> 0x0000
        i2c_start;
        write_byte(8'hA0, a);
        write_byte(8'h1F, a);
        write_byte(8'hFF, a);
        write_byte(8'hC3, a); check("top_ack_data", {15'd0, a}, 16'd0);
        i2c_stop;
        check("top_addr", {3'd0, addr_log[n_pulse-1]}, 16'h1FFF);
        set_ptr_read(8'h1F, 8'hFF, "sq2");
        read_byte(1'b0, d); check("sq2_d0", {8'd0, d}, 16'h00C3);
        read_byte(1'b1, d); check("sq2_d1", {8'd0, d}, 16'h0033);
        i2c_stop;

        // Upper word-address bits are ignored: 0xE1,0x23 selects 0x0123
        set_ptr_read(8'hE1, 8'h23, "hi");
        read_byte(1'b1, d); check("hi_data", {8'd0, d}, 16'h005A);
        i2c_stop;

        // Device address mismatch: no ACK, busy until STOP, no writes
        p0 = n_pulse;
        i2c_start;
        write_byte(8'hA2, a); check("mm_nack", {15'd0, a}, 16'd1);
        check("mm_busy", {15'd0, busy}, 16'd1);
        write_byte(8'h55, a); check("mm_ignored", {15'd0, a}, 16'd1);
        i2c_stop;
        check("mm_busy_stop", {15'd0, busy},       16'd0);
        check("mm_no_write",  16'(n_pulse - p0),   16'd0);

        // Reset while the target is driving the device-address ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_cycle(((8'hA0 >> i) & 8'h01) != 8'h00, a);
        check("mr_ack_driven", {15'd0, bus.sda_oe}, 16'd1);
        sys_rst = 1'b1;
        wait_cyc(1);
        check("mr_sda_oe", {15'd0, bus.sda_oe}, 16'd0);
        check("mr_busy",   {15'd0, busy},       16'd0);
        check("mr_wr_addr",{3'd0, wr_addr},     16'd0);
        sys_rst = 1'b0;
        wait_cyc(4);
        i2c_stop;
        set_ptr_read(8'h01, 8'h23, "ar");
        read_byte(1'b1, d); check("ar_data", {8'd0, d}, 16'h005A);
        i2c_stop;

`ifdef IIC_WP_EN
        // Write protection: data NACKed, memory and strobes untouched
        i2c_start;
        write_byte(8'hA0, a);
        write_byte(8'h00, a);
        write_byte(8'h40, a);
        write_byte(8'h12, a); check("wp_pre_ack", {15'd0, a}, 16'd0);
        i2c_stop;
        p0 = n_pulse;
        wp = 1'b1;
        i2c_start;
        write_byte(8'hA0, a); check("wp_ack_dev", {15'd0, a}, 16'd0);
        write_byte(8'h00, a); check("wp_ack_hi",  {15'd0, a}, 16'd0);
        write_byte(8'h40, a); check("wp_ack_lo",  {15'd0, a}, 16'd0);
        write_byte(8'h77, a); check("wp_nack",    {15'd0, a}, 16'd1);
        i2c_stop;
        wp = 1'b0;
        check("wp_no_pulse", 16'(n_pulse - p0), 16'd0);
        set_ptr_read(8'h00, 8'h40, "wp");
        read_byte(1'b1, d); check("wp_data", {8'd0, d}, 16'h0012);
        i2c_stop;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
